// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control: register address width,
// sequencer state encoding and the NOP control word used when ID/EX is bubbled.
package mips_pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MWAIT  = 2'd2
  } pipe_state_e;

  // ID/EX control fields; a bubble replaces them with IDEX_CTRL_NOP.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } idex_ctrl_t;

  localparam idex_ctrl_t IDEX_CTRL_NOP = '0;

endpackage

// File: rtl/load_use_cmp.sv
// Load-use comparator: flags an ID source register that matches the load destination in EX.
// Purely combinational so it can be shared with the forwarding unit.
module load_use_cmp
  import mips_pipe_pkg::*;
(
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  output logic                  lu_hit_c
);

  // $zero is never a real dependency
  always_comb begin
    lu_hit_c = ex_mem_read && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, branch flush and data-memory freeze with sticky timeout.
// Define HAZARD_PERF_CNT_EN to add the stall-cycle and flush performance counters.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned LOAD_USE_STALLS = 1,
  parameter int unsigned MEM_TIMEOUT     = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rt,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic                  i_ex_branch_taken,
  input  logic                  i_mem_busy,
  output logic                  o_pc_write,
  output logic                  o_ifid_write,
  output logic                  o_ifid_flush,
  output logic                  o_idex_bubble,
  output logic                  o_idex_hold,
  output logic                  o_exmem_hold,
  output logic                  o_mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           o_stall_cycles,
  output logic [15:0]           o_flush_count
`endif
);

  localparam int unsigned STALL_W = 2;
  localparam int unsigned TMO_W   = 16;

  pipe_state_e        state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               tmo_flag_q, tmo_flag_d;
  logic               lu_hit;

  load_use_cmp u_load_use_cmp (
    .ex_mem_read (i_ex_mem_read),
    .ex_rt       (i_ex_rt),
    .id_rs       (i_id_rs),
    .id_rt       (i_id_rt),
    .id_uses_rt  (i_id_uses_rt),
    .lu_hit_c    (lu_hit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= RUN;
      stall_q    <= '0;
      tmo_q      <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      tmo_q      <= tmo_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  // Next state and Mealy controls; priority is mem_busy > branch > load-use
  always_comb begin
    state_d       = state_q;
    stall_d       = stall_q;
    tmo_d         = tmo_q;
    tmo_flag_d    = tmo_flag_q;
    o_pc_write    = 1'b1;
    o_ifid_write  = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_idex_hold   = 1'b0;
    o_exmem_hold  = 1'b0;

    case (state_q)
      RUN: begin
        if (i_mem_busy) begin
          o_pc_write   = 1'b0;
          o_ifid_write = 1'b0;
          o_idex_hold  = 1'b1;
          o_exmem_hold = 1'b1;
          tmo_d        = TMO_W'(1);
          state_d      = MWAIT;
        end else if (i_ex_branch_taken) begin
          o_ifid_flush  = 1'b1;
          o_idex_bubble = 1'b1;
        end else if (lu_hit) begin
          o_pc_write    = 1'b0;
          o_ifid_write  = 1'b0;
          o_idex_bubble = 1'b1;
          if (LOAD_USE_STALLS > 1) begin
            stall_d = STALL_W'(LOAD_USE_STALLS - 1);
            state_d = LSTALL;
          end
        end
      end
      LSTALL: begin
        o_pc_write   = 1'b0;
        o_ifid_write = 1'b0;
        if (i_mem_busy) begin
          o_idex_hold  = 1'b1;
          o_exmem_hold = 1'b1;
          tmo_d        = TMO_W'(1);
          state_d      = MWAIT;
        end else begin
          o_idex_bubble = 1'b1;
          stall_d       = stall_q - STALL_W'(1);
          if (stall_q == STALL_W'(1)) begin
            state_d = RUN;
          end
        end
      end
      MWAIT: begin
        if (i_mem_busy) begin
          o_pc_write   = 1'b0;
          o_ifid_write = 1'b0;
          o_idex_hold  = 1'b1;
          o_exmem_hold = 1'b1;
          if (tmo_q != TMO_W'(MEM_TIMEOUT)) begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end else begin
          tmo_d   = '0;
          state_d = (stall_q != '0) ? LSTALL : RUN;
        end
      end
      default: begin
        state_d = RUN;
        stall_d = '0;
        tmo_d   = '0;
      end
    endcase

    if (i_mem_busy && (tmo_d == TMO_W'(MEM_TIMEOUT))) begin
      tmo_flag_d = 1'b1;
    end

    // Outputs follow reset asynchronously, without waiting for a clock
    if (!i_rst_n) begin
      o_pc_write    = 1'b0;
      o_ifid_write  = 1'b0;
      o_ifid_flush  = 1'b1;
      o_idex_bubble = 1'b1;
      o_idex_hold   = 1'b0;
      o_exmem_hold  = 1'b0;
    end
  end

  assign o_mem_timeout = tmo_flag_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;
  logic        flush_accept;

  assign flush_accept = (state_q == RUN) && !i_mem_busy && i_ex_branch_taken;

  // Stall counter wraps; flush counter saturates
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!o_pc_write) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (flush_accept && (flush_count_q != 16'hFFFF)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign o_stall_cycles = stall_cycles_q;
  assign o_flush_count  = flush_count_q;
`else
  // Performance counters not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (1 and 3 load-use bubbles) share stimulus.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic       mr;
    logic [4:0] ert;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       br;
    logic       busy;
  } stim_t;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold, mem_timeout}
  localparam logic [6:0] DEF = 7'b1100000;
  localparam logic [6:0] BUB = 7'b0001000;
  localparam logic [6:0] FRZ = 7'b0000110;
  localparam logic [6:0] BR  = 7'b1111000;
  localparam logic [6:0] RST = 7'b0011000;
  localparam logic [6:0] TMO = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, br_taken = 1'b0, mem_busy = 1'b0;

  logic pcw1, ifw1, iff1, bub1, idh1, exh1, tmo1;
  logic pcw3, ifw3, iff3, bub3, idh3, exh3, tmo3;
  logic [6:0] obs1, obs3;
  assign obs1 = {pcw1, ifw1, iff1, bub1, idh1, exh1, tmo1};
  assign obs3 = {pcw3, ifw3, iff3, bub3, idh3, exh3, tmo3};

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, sc3;
  logic [15:0] fc1, fc3;
`endif

  logic [6:0] exp1_q[$];
  logic [6:0] exp3_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LOAD_USE_STALLS(1), .MEM_TIMEOUT(8)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_ex_branch_taken(br_taken), .i_mem_busy(mem_busy),
    .o_pc_write(pcw1), .o_ifid_write(ifw1), .o_ifid_flush(iff1), .o_idex_bubble(bub1),
    .o_idex_hold(idh1), .o_exmem_hold(exh1), .o_mem_timeout(tmo1)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cycles(sc1), .o_flush_count(fc1)
`endif
  );

  pipe_hazard_ctrl #(.LOAD_USE_STALLS(3), .MEM_TIMEOUT(8)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_ex_branch_taken(br_taken), .i_mem_busy(mem_busy),
    .o_pc_write(pcw3), .o_ifid_write(ifw3), .o_ifid_flush(iff3), .o_idex_bubble(bub3),
    .o_idex_hold(idh3), .o_exmem_hold(exh3), .o_mem_timeout(tmo3)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cycles(sc3), .o_flush_count(fc3)
`endif
  );

  function automatic stim_t mk(input logic r, input logic mr, input logic [4:0] ert,
                               input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                               input logic br, input logic busy);
    stim_t s;
    s = '{rst_n: r, mr: mr, ert: ert, rs: rs, rt: rt, ur: ur, br: br, busy: busy};
    return s;
  endfunction

  // Apply one cycle of stimulus, queue the expectations, advance to the sampling edge
  task automatic drive(input stim_t s, input logic [6:0] x1, input logic [6:0] x3);
    rst_n       = s.rst_n;
    ex_mem_read = s.mr;
    ex_rt       = s.ert;
    id_rs       = s.rs;
    id_rt       = s.rt;
    id_uses_rt  = s.ur;
    br_taken    = s.br;
    mem_busy    = s.busy;
    exp1_q.push_back(x1);
    exp3_q.push_back(x3);
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t s[3];
    logic [6:0] x1[3], x3[3];
    logic [6:0] e1, e3;
    s[0] = mk(0, 1, 5, 5, 0, 0, 0, 0); x1[0] = RST; x3[0] = RST;
    s[1] = mk(0, 0, 0, 0, 0, 0, 1, 1); x1[1] = RST; x3[1] = RST;
    s[2] = mk(1, 0, 0, 0, 0, 0, 0, 0); x1[2] = DEF; x3[2] = DEF;
    for (int i = 0; i < 3; i++) begin
      drive(s[i], x1[i], x3[i]);
      e1 = exp1_q.pop_front();
      e3 = exp3_q.pop_front();
      n_cmp += 2;
      if (obs1 !== e1) begin n_fail++; $display("FAIL reset[%0d] lus1: got %b want %b", i, obs1, e1); end
      if (obs3 !== e3) begin n_fail++; $display("FAIL reset[%0d] lus3: got %b want %b", i, obs3, e3); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s[5];
    logic [6:0] x1[5], x3[5];
    logic [6:0] e1, e3;
    s[0] = mk(1, 1, 5, 5, 9, 1, 0, 0); x1[0] = BUB; x3[0] = BUB;
    s[1] = mk(1, 0, 0, 5, 9, 1, 0, 0); x1[1] = DEF; x3[1] = BUB;
    s[2] = mk(1, 0, 0, 5, 9, 1, 0, 0); x1[2] = DEF; x3[2] = BUB;
    s[3] = mk(1, 0, 0, 5, 9, 1, 0, 0); x1[3] = DEF; x3[3] = DEF;
    s[4] = mk(1, 0, 0, 5, 9, 1, 0, 0); x1[4] = DEF; x3[4] = DEF;
    for (int i = 0; i < 5; i++) begin
      drive(s[i], x1[i], x3[i]);
      e1 = exp1_q.pop_front();
      e3 = exp3_q.pop_front();
      n_cmp += 2;
      if (obs1 !== e1) begin n_fail++; $display("FAIL load_use[%0d] lus1: got %b want %b", i, obs1, e1); end
      if (obs3 !== e3) begin n_fail++; $display("FAIL load_use[%0d] lus3: got %b want %b", i, obs3, e3); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_no_stall();
    stim_t s[7];
    logic [6:0] x1[7], x3[7];
    logic [6:0] e1, e3;
    s[0] = mk(1, 1, 0, 0, 0, 1, 0, 0); x1[0] = DEF; x3[0] = DEF;
    s[1] = mk(1, 1, 7, 3, 7, 0, 0, 0); x1[1] = DEF; x3[1] = DEF;
    s[2] = mk(1, 0, 7, 7, 7, 1, 0, 0); x1[2] = DEF; x3[2] = DEF;
    s[3] = mk(1, 1, 7, 3, 7, 1, 0, 0); x1[3] = BUB; x3[3] = BUB;
    s[4] = mk(1, 0, 0, 3, 7, 1, 0, 0); x1[4] = DEF; x3[4] = BUB;
    s[5] = mk(1, 0, 0, 3, 7, 1, 0, 0); x1[5] = DEF; x3[5] = BUB;
    s[6] = mk(1, 0, 0, 3, 7, 1, 0, 0); x1[6] = DEF; x3[6] = DEF;
    for (int i = 0; i < 7; i++) begin
      drive(s[i], x1[i], x3[i]);
      e1 = exp1_q.pop_front();
      e3 = exp3_q.pop_front();
      n_cmp += 2;
      if (obs1 !== e1) begin n_fail++; $display("FAIL no_stall[%0d] lus1: got %b want %b", i, obs1, e1); end
      if (obs3 !== e3) begin n_fail++; $display("FAIL no_stall[%0d] lus3: got %b want %b", i, obs3, e3); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_priority();
    stim_t s[7];
    logic [6:0] x1[7], x3[7];
    logic [6:0] e1, e3;
    s[0] = mk(1, 1, 4, 4, 0, 0, 1, 0); x1[0] = BR;  x3[0] = BR;
    s[1] = mk(1, 0, 0, 4, 0, 0, 0, 0); x1[1] = DEF; x3[1] = DEF;
    s[2] = mk(1, 0, 0, 0, 0, 0, 1, 0); x1[2] = BR;  x3[2] = BR;
    s[3] = mk(1, 0, 0, 0, 0, 0, 0, 0); x1[3] = DEF; x3[3] = DEF;
    s[4] = mk(1, 1, 4, 4, 0, 0, 1, 1); x1[4] = FRZ; x3[4] = FRZ;
    s[5] = mk(1, 0, 0, 0, 0, 0, 0, 0); x1[5] = DEF; x3[5] = DEF;
    s[6] = mk(1, 0, 0, 0, 0, 0, 0, 0); x1[6] = DEF; x3[6] = DEF;
    for (int i = 0; i < 7; i++) begin
      drive(s[i], x1[i], x3[i]);
      e1 = exp1_q.pop_front();
      e3 = exp3_q.pop_front();
      n_cmp += 2;
      if (obs1 !== e1) begin n_fail++; $display("FAIL branch[%0d] lus1: got %b want %b", i, obs1, e1); end
      if (obs3 !== e3) begin n_fail++; $display("FAIL branch[%0d] lus3: got %b want %b", i, obs3, e3); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lstall_busy();
    stim_t s[9];
    logic [6:0] x1[9], x3[9];
    logic [6:0] e1, e3;
    s[0] = mk(1, 1, 6, 6, 0, 0, 0, 0); x1[0] = BUB; x3[0] = BUB;
    for (int i = 1; i < 5; i++) begin
      s[i] = mk(1, 0, 0, 6, 0, 0, 0, 1); x1[i] = FRZ; x3[i] = FRZ;
    end
    s[5] = mk(1, 0, 0, 0, 0, 0, 0, 0); x1[5] = DEF; x3[5] = DEF;
    s[6] = mk(1, 0, 0, 0, 0, 0, 0, 0); x1[6] = DEF; x3[6] = BUB;
    s[7] = mk(1, 0, 0, 0, 0, 0, 0, 0); x1[7] = DEF; x3[7] = BUB;
    s[8] = mk(1, 0, 0, 0, 0, 0, 0, 0); x1[8] = DEF; x3[8] = DEF;
    for (int i = 0; i < 9; i++) begin
      drive(s[i], x1[i], x3[i]);
      e1 = exp1_q.pop_front();
      e3 = exp3_q.pop_front();
      n_cmp += 2;
      if (obs1 !== e1) begin n_fail++; $display("FAIL lstall_busy[%0d] lus1: got %b want %b", i, obs1, e1); end
      if (obs3 !== e3) begin n_fail++; $display("FAIL lstall_busy[%0d] lus3: got %b want %b", i, obs3, e3); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[4];
    logic [6:0] x1[4], x3[4];
    logic [6:0] e1, e3;
    s[0] = mk(1, 1, 5, 5, 0, 0, 0, 0); x1[0] = BUB; x3[0] = BUB;
    s[1] = mk(1, 1, 8, 2, 8, 1, 0, 0); x1[1] = BUB; x3[1] = BUB;
    s[2] = mk(1, 0, 0, 2, 8, 1, 0, 0); x1[2] = DEF; x3[2] = BUB;
    s[3] = mk(1, 0, 0, 2, 8, 1, 0, 0); x1[3] = DEF; x3[3] = DEF;
    for (int i = 0; i < 4; i++) begin
      drive(s[i], x1[i], x3[i]);
      e1 = exp1_q.pop_front();
      e3 = exp3_q.pop_front();
      n_cmp += 2;
      if (obs1 !== e1) begin n_fail++; $display("FAIL back_to_back[%0d] lus1: got %b want %b", i, obs1, e1); end
      if (obs3 !== e3) begin n_fail++; $display("FAIL back_to_back[%0d] lus3: got %b want %b", i, obs3, e3); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    stim_t s[14];
    logic [6:0] x1[14], x3[14];
    logic [6:0] e1, e3;
    for (int i = 0; i < 10; i++) begin
      s[i]  = mk(1, 0, 0, 0, 0, 0, 0, 1);
      x1[i] = (i < 8) ? FRZ : (FRZ | TMO);
      x3[i] = x1[i];
    end
    s[10] = mk(1, 0, 0, 0, 0, 0, 0, 0); x1[10] = DEF | TMO; x3[10] = DEF | TMO;
    s[11] = mk(1, 0, 0, 0, 0, 0, 0, 0); x1[11] = DEF | TMO; x3[11] = DEF | TMO;
    s[12] = mk(0, 0, 0, 0, 0, 0, 0, 0); x1[12] = RST;       x3[12] = RST;
    s[13] = mk(1, 0, 0, 0, 0, 0, 0, 0); x1[13] = DEF;       x3[13] = DEF;
    for (int i = 0; i < 14; i++) begin
      drive(s[i], x1[i], x3[i]);
      e1 = exp1_q.pop_front();
      e3 = exp3_q.pop_front();
      n_cmp += 2;
      if (obs1 !== e1) begin n_fail++; $display("FAIL timeout[%0d] lus1: got %b want %b", i, obs1, e1); end
      if (obs3 !== e3) begin n_fail++; $display("FAIL timeout[%0d] lus3: got %b want %b", i, obs3, e3); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_abort();
    stim_t s[8];
    logic [6:0] x1[8], x3[8];
    logic [6:0] e1, e3;
    s[0] = mk(1, 1, 5, 5, 0, 0, 0, 0); x1[0] = BUB; x3[0] = BUB;
    s[1] = mk(0, 0, 0, 5, 0, 0, 0, 0); x1[1] = RST; x3[1] = RST;
    s[2] = mk(1, 0, 0, 5, 0, 0, 0, 0); x1[2] = DEF; x3[2] = DEF;
    s[3] = mk(1, 0, 0, 0, 0, 0, 0, 1); x1[3] = FRZ; x3[3] = FRZ;
    s[4] = mk(1, 0, 0, 0, 0, 0, 0, 1); x1[4] = FRZ; x3[4] = FRZ;
    s[5] = mk(0, 0, 0, 0, 0, 0, 0, 1); x1[5] = RST; x3[5] = RST;
    s[6] = mk(1, 0, 0, 0, 0, 0, 0, 0); x1[6] = DEF; x3[6] = DEF;
    s[7] = mk(1, 0, 0, 0, 0, 0, 0, 0); x1[7] = DEF; x3[7] = DEF;
    for (int i = 0; i < 8; i++) begin
      drive(s[i], x1[i], x3[i]);
      e1 = exp1_q.pop_front();
      e3 = exp3_q.pop_front();
      n_cmp += 2;
      if (obs1 !== e1) begin n_fail++; $display("FAIL reset_abort[%0d] lus1: got %b want %b", i, obs1, e1); end
      if (obs3 !== e3) begin n_fail++; $display("FAIL reset_abort[%0d] lus3: got %b want %b", i, obs3, e3); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_priority();
    test_lstall_busy();
    test_back_to_back();
    test_timeout();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
